// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding and constants for the pipeline controller
package pipeline_ctrl_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, IMISS = 2'd1, DMISS = 2'd2, ERR = 2'd3} state_t;
    typedef enum logic [2:0] {M_NONE, M_FREEZE, M_BRANCH, M_IMISS, M_LU, M_ERR} mode_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int MISS_TIMEOUT_DEF = 64;
endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// load_use_detect: flags an ID instruction reading the destination of a load sitting in EX
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);
    assign load_use = ex_mem_read && ex_rt != REG_ZERO && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline with miss timeout detection
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MISS_TIMEOUT = MISS_TIMEOUT_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             icache_hit,
    input  logic             dmem_req,
    input  logic             dcache_hit,
    input  logic             branch_taken,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic [1:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int WW = $clog2(MISS_TIMEOUT + 1);

    state_t        st, nxt;
    mode_t         mode, run_mode;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          load_use, dmiss, imiss, timeout;

    load_use_detect u_lud (
        .ex_mem_read(ex_mem_read),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .load_use   (load_use)
    );

    assign dmiss   = dmem_req && !dcache_hit;
    assign imiss   = !icache_hit;
    assign timeout = wait_cnt == WW'(MISS_TIMEOUT);

    // pick the pipeline action for this cycle and the next state / wait count
    always_comb begin
        run_mode = dmiss ? M_FREEZE : branch_taken ? M_BRANCH : imiss ? M_IMISS : load_use ? M_LU : M_NONE;
        mode     = run_mode;
        nxt      = RUN;
        wait_nxt = '0;
        case (st)
            RUN: begin
                nxt      = dmiss ? DMISS : run_mode == M_IMISS ? IMISS : RUN;
                wait_nxt = nxt == RUN ? '0 : WW'(1);
            end
            DMISS: if (!dcache_hit) begin
                mode     = M_FREEZE;
                nxt      = timeout ? ERR : DMISS;
                wait_nxt = wait_cnt + WW'(1);
            end
            IMISS: if (!dmiss && !branch_taken && imiss) begin
                mode     = M_IMISS;
                nxt      = timeout ? ERR : IMISS;
                wait_nxt = wait_cnt + WW'(1);
            end else begin
                nxt      = dmiss ? DMISS : RUN;
                wait_nxt = dmiss ? WW'(1) : '0;
            end
            default: begin
                mode     = M_ERR;
                nxt      = ERR;
                wait_nxt = wait_cnt;
            end
        endcase
    end

    assign pc_en        = mode == M_NONE || mode == M_BRANCH;
    assign if_id_en     = !(mode == M_FREEZE || mode == M_LU || mode == M_ERR);
    assign if_id_flush  = mode == M_BRANCH || mode == M_IMISS;
    assign id_ex_en     = !(mode == M_FREEZE || mode == M_ERR);
    assign id_ex_flush  = mode == M_BRANCH || mode == M_LU;
    assign ex_mem_en    = !(mode == M_FREEZE || mode == M_ERR);
    assign mem_wb_flush = mode == M_FREEZE;
    assign state        = st;
    assign err          = st == ERR;

    // state, miss wait counter and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= RUN;
            wait_cnt     <= '0;
            stall_cycles <= '0;
        end else begin
            st       <= nxt;
            wait_cnt <= wait_nxt;
            if (!pc_en && !(&stall_cycles))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scoreboard bench for the pipeline stall/flush sequencer
module tb_pipeline_ctrl;
    // output vector order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
    localparam logic [6:0] O_DEF = 7'b1101010;
    localparam logic [6:0] O_LU  = 7'b0001110;
    localparam logic [6:0] O_FRZ = 7'b0000001;
    localparam logic [6:0] O_BR  = 7'b1111110;
    localparam logic [6:0] O_IM  = 7'b0111010;
    localparam logic [6:0] O_ERR = 7'b0000000;

    typedef struct {
        string       tag;
        logic [6:0]  o;
        logic [1:0]  s;
        logic        e;
        logic [15:0] st;
    } exp_t;

    logic clk = 0, rst_n = 0;
    logic icache_hit, dmem_req, dcache_hit, branch_taken, ex_mem_read, id_uses_rt;
    logic [4:0] ex_rt, id_rs, id_rt;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, err;
    logic [1:0] state;
    logic [15:0] stall_cycles;
    logic pc_en2, if_id_en2, if_id_flush2, id_ex_en2, id_ex_flush2, ex_mem_en2, mem_wb_flush2, err2;
    logic [1:0] state2, stall2;

    exp_t q[$];
    logic [15:0] exp_stall = 0;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MISS_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .icache_hit(icache_hit), .dmem_req(dmem_req), .dcache_hit(dcache_hit),
        .branch_taken(branch_taken), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_flush(mem_wb_flush),
        .state(state), .err(err), .stall_cycles(stall_cycles)
    );

    pipeline_ctrl #(.MISS_TIMEOUT(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .icache_hit(icache_hit), .dmem_req(dmem_req), .dcache_hit(dcache_hit),
        .branch_taken(branch_taken), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .pc_en(pc_en2), .if_id_en(if_id_en2), .if_id_flush(if_id_flush2),
        .id_ex_en(id_ex_en2), .id_ex_flush(id_ex_flush2), .ex_mem_en(ex_mem_en2), .mem_wb_flush(mem_wb_flush2),
        .state(state2), .err(err2), .stall_cycles(stall2)
    );

    task automatic idle();
        icache_hit = 1; dmem_req = 0; dcache_hit = 1; branch_taken = 0;
        ex_mem_read = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    endtask

    task automatic check();
        exp_t x;
        logic [6:0] obs;
        logic [1:0] sat;
        x   = q.pop_front();
        obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};
        sat = x.st > 3 ? 2'd3 : x.st[1:0];
        vectors++;
        assert (obs === x.o) else begin miscompares++; $error("FAIL %s outputs got %b want %b", x.tag, obs, x.o); end
        assert (state === x.s) else begin miscompares++; $error("FAIL %s state got %0d want %0d", x.tag, state, x.s); end
        assert (err === x.e) else begin miscompares++; $error("FAIL %s err got %b want %b", x.tag, err, x.e); end
        assert (stall_cycles === x.st) else begin miscompares++; $error("FAIL %s stall got %0d want %0d", x.tag, stall_cycles, x.st); end
        assert (stall2 === sat) else begin miscompares++; $error("FAIL %s stall_sat got %0d want %0d", x.tag, stall2, sat); end
    endtask

    // one pipeline cycle: inputs already driven, expectations queued, sampled on the falling edge
    task automatic step(input string tag, input logic [6:0] eo, input logic [1:0] es);
        q.push_back('{tag, eo, es, es == 2'd3, exp_stall});
        @(negedge clk);
        check();
        if (!eo[6]) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        q.push_back('{"in_reset", O_DEF, 2'd0, 1'b0, 16'd0});
        check();
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) step("idle", O_DEF, 2'd0);

        ex_mem_read = 1; ex_rt = 5; id_rs = 5;
        step("lu_rs", O_LU, 2'd0);
        idle();
        step("after_lu", O_DEF, 2'd0);
        ex_mem_read = 1; ex_rt = 0; id_rs = 0;
        step("lu_r0", O_DEF, 2'd0);
        ex_rt = 7; id_rt = 7; id_uses_rt = 1;
        step("lu_rt", O_LU, 2'd0);
        id_uses_rt = 0;
        step("lu_rt_unused", O_DEF, 2'd0);
        idle();

        dmem_req = 1; dcache_hit = 0;
        step("dmiss0", O_FRZ, 2'd0);
        step("dmiss1", O_FRZ, 2'd2);
        step("dmiss2", O_FRZ, 2'd2);
        dcache_hit = 1;
        step("dhit", O_DEF, 2'd2);
        idle();
        step("after_dmiss", O_DEF, 2'd0);

        icache_hit = 0;
        step("imiss0", O_IM, 2'd0);
        branch_taken = 1;
        step("imiss_br", O_BR, 2'd1);
        idle();
        step("after_imiss_br", O_DEF, 2'd0);

        icache_hit = 0;
        step("imiss_a", O_IM, 2'd0);
        icache_hit = 1; ex_mem_read = 1; ex_rt = 3; id_rs = 3;
        step("ihit_lu", O_LU, 2'd1);
        idle();
        step("after_ihit", O_DEF, 2'd0);

        icache_hit = 0;
        step("imiss_b", O_IM, 2'd0);
        dmem_req = 1; dcache_hit = 0;
        step("imiss_dmiss", O_FRZ, 2'd1);
        step("to_dmiss", O_FRZ, 2'd2);
        dcache_hit = 1; icache_hit = 1;
        step("dhit_b", O_DEF, 2'd2);
        idle();
        step("after_b", O_DEF, 2'd0);

        dmem_req = 1; dcache_hit = 0; branch_taken = 1; ex_mem_read = 1; ex_rt = 9; id_rs = 9;
        step("combo", O_FRZ, 2'd0);
        step("combo_hold", O_FRZ, 2'd2);
        dcache_hit = 1;
        step("combo_hit_br", O_BR, 2'd2);
        idle();
        step("after_combo", O_DEF, 2'd0);

        dmem_req = 1; dcache_hit = 0;
        step("to_run", O_FRZ, 2'd0);
        for (int i = 0; i < 4; i++) step("to_wait", O_FRZ, 2'd2);
        step("err", O_ERR, 2'd3);
        idle();
        step("err_sticky", O_ERR, 2'd3);
        step("err_sticky2", O_ERR, 2'd3);

        rst_n = 0;
        #1;
        exp_stall = 0;
        q.push_back('{"async_rst", O_DEF, 2'd0, 1'b0, 16'd0});
        check();
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        step("post_rst", O_DEF, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
